// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALUOp,
// opcodes and the datapath mux/ALU select codes.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } statetype_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// ALU operation decoder: maps ALUOp plus instruction function fields to ALUControl.
// Purely combinational, zero latency, no flow control.
module aludec
  import riscv_mc_pkg::*;
(
  input  logic       op5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [1:0] alu_op_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type uses funct7b5 to pick sub; addi ignores it.
          3'b000:  alu_control_o = ({op5_i, funct7b5_i} == 2'b11) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I datapath plus retired-instruction counter.
// lw 5 cycles, sw/R/I/jal 4, beq 3; each mem_ready=0 cycle in a memory state stalls one cycle.
module multicycle_ctrl
  import riscv_mc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic                 illegal_op,
  output logic [INSTRET_W-1:0] instret
);

  statetype_t           state_q, state_d;
  logic [INSTRET_W-1:0] instret_q;
  logic [1:0]           alu_op;
  logic                 pc_update, branch, retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECUTER;
          OP_I:              state_d = EXECUTEI;
          OP_BEQ:            state_d = BEQ;
          OP_JAL:            state_d = JAL;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: ImmSrc = IMM_S;
      OP_BEQ:   ImmSrc = IMM_B;
      OP_JAL:   ImmSrc = IMM_J;
      default:  ImmSrc = IMM_I;
    endcase
  end

  assign PCWrite = pc_update | (branch & zero);
  assign instret = instret_q;

  aludec u_aludec (
    .op5_i         (op[5]),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_op_i      (alu_op),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scenario bench for multicycle_ctrl: per-cycle expected outputs are queued with
// their stimulus and compared as each cycle is driven; instret is 4 bits to reach wrap.
module tb_multicycle_ctrl;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    op = '0;
  logic [2:0]    funct3 = '0;
  logic          funct7b5 = 1'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal_op;
  logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]    ALUControl;
  logic [IW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal_op(illegal_op), .instret(instret)
  );

  typedef struct packed {
    logic mem_req, adr, mw, irw, pcw, rw;
    logic [1:0] sa, sb, rs, imm;
    logic [2:0] ac;
    logic ill;
  } outs_t;

  typedef struct packed {
    logic rst; logic [6:0] op; logic [2:0] f3; logic f7; logic z; logic rdy;
  } stim_t;

  typedef struct packed { outs_t o; logic [IW-1:0] ir; } exp_t;

  outs_t got;
  assign got = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal_op};

  stim_t stim_q[$];
  exp_t  exp_q[$];
  string lbl_q[$];

  int          checks = 0;
  int          failures = 0;
  int unsigned n_ret = 0;
  logic [6:0]  cur_op = '0;
  logic [2:0]  cur_f3 = '0;
  logic        cur_f7 = 1'b0;
  logic        cur_z = 1'b0;

  // Argument order: mem_req AdrSrc MemWrite IRWrite PCWrite RegWrite SrcA SrcB Result Imm ALUCtl illegal
  function automatic outs_t mk(int mr, int ad, int mw, int irw, int pcw, int rw,
                               int sa, int sb, int rs, int im, int ac, int il);
    outs_t r;
    r = {1'(mr), 1'(ad), 1'(mw), 1'(irw), 1'(pcw), 1'(rw),
         2'(sa), 2'(sb), 2'(rs), 2'(im), 3'(ac), 1'(il)};
    return r;
  endfunction

  function automatic void push(string l, int rdy, int rst, outs_t o);
    stim_t s;
    exp_t  e;
    s = {1'(rst), cur_op, cur_f3, cur_f7, cur_z, 1'(rdy)};
    e = {o, IW'(n_ret)};
    stim_q.push_back(s);
    exp_q.push_back(e);
    lbl_q.push_back(l);
  endfunction

  task automatic apply_next();
    stim_t s;
    @(negedge clk);
    s = stim_q.pop_front();
    reset = s.rst; op = s.op; funct3 = s.f3; funct7b5 = s.f7; zero = s.z; mem_ready = s.rdy;
    #1;
  endtask

  task automatic test_reset();
    cur_op = 7'b0000011; cur_f3 = 3'b010;
    push("rst_fetch_wait", 0, 0, mk(1,0,0,0,0,0, 0,2,2,0,0,0));
    while (exp_q.size() != 0) begin
      exp_t e; string l;
      apply_next(); e = exp_q.pop_front(); l = lbl_q.pop_front();
      checks++;
      if (got !== e.o) begin failures++; $display("FAIL reset %s outs got=%h exp=%h", l, got, e.o); end
      checks++;
      if (instret !== e.ir) begin failures++; $display("FAIL reset %s instret got=%0d exp=%0d", l, instret, e.ir); end
    end
  endtask

  task automatic test_lw();
    cur_op = 7'b0000011; cur_f3 = 3'b010;
    push("lw_fetch",   1, 0, mk(1,0,0,1,1,0, 0,2,2,0,0,0));
    push("lw_decode",  1, 0, mk(0,0,0,0,0,0, 1,1,0,0,0,0));
    push("lw_memadr",  0, 0, mk(0,0,0,0,0,0, 2,1,0,0,0,0));
    push("lw_memread", 1, 0, mk(1,1,0,0,0,0, 0,0,0,0,0,0));
    push("lw_memwb",   0, 0, mk(0,0,0,0,0,1, 0,0,1,0,0,0));
    n_ret++;
    while (exp_q.size() != 0) begin
      exp_t e; string l;
      apply_next(); e = exp_q.pop_front(); l = lbl_q.pop_front();
      checks++;
      if (got !== e.o) begin failures++; $display("FAIL lw %s outs got=%h exp=%h", l, got, e.o); end
      checks++;
      if (instret !== e.ir) begin failures++; $display("FAIL lw %s instret got=%0d exp=%0d", l, instret, e.ir); end
    end
  endtask

  task automatic test_sw_stall();
    cur_op = 7'b0100011; cur_f3 = 3'b010;
    push("sw_fetch",   1, 0, mk(1,0,0,1,1,0, 0,2,2,1,0,0));
    push("sw_decode",  0, 0, mk(0,0,0,0,0,0, 1,1,0,1,0,0));
    push("sw_memadr",  1, 0, mk(0,0,0,0,0,0, 2,1,0,1,0,0));
    push("sw_wait0",   0, 0, mk(1,1,1,0,0,0, 0,0,0,1,0,0));
    push("sw_wait1",   0, 0, mk(1,1,1,0,0,0, 0,0,0,1,0,0));
    push("sw_done",    1, 0, mk(1,1,1,0,0,0, 0,0,0,1,0,0));
    n_ret++;
    while (exp_q.size() != 0) begin
      exp_t e; string l;
      apply_next(); e = exp_q.pop_front(); l = lbl_q.pop_front();
      checks++;
      if (got !== e.o) begin failures++; $display("FAIL sw %s outs got=%h exp=%h", l, got, e.o); end
      checks++;
      if (instret !== e.ir) begin failures++; $display("FAIL sw %s instret got=%0d exp=%0d", l, instret, e.ir); end
    end
  endtask

  task automatic test_rtype();
    int f3s[5] = '{0, 7, 2, 6, 0};
    int f7s[5] = '{1, 0, 0, 0, 0};
    int acs[5] = '{1, 2, 5, 3, 0};
    cur_op = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      cur_f3 = 3'(f3s[i]); cur_f7 = 1'(f7s[i]);
      push("r_fetch",  1, 0, mk(1,0,0,1,1,0, 0,2,2,0,0,0));
      push("r_decode", 1, 0, mk(0,0,0,0,0,0, 1,1,0,0,0,0));
      push("r_exec",   1, 0, mk(0,0,0,0,0,0, 2,0,0,0,acs[i],0));
      push("r_wb",     1, 0, mk(0,0,0,0,0,1, 0,0,0,0,0,0));
      n_ret++;
    end
    while (exp_q.size() != 0) begin
      exp_t e; string l;
      apply_next(); e = exp_q.pop_front(); l = lbl_q.pop_front();
      checks++;
      if (got !== e.o) begin failures++; $display("FAIL rtype %s outs got=%h exp=%h", l, got, e.o); end
      checks++;
      if (instret !== e.ir) begin failures++; $display("FAIL rtype %s instret got=%0d exp=%0d", l, instret, e.ir); end
    end
  endtask

  task automatic test_jal();
    cur_op = 7'b1101111; cur_f3 = 3'b000; cur_f7 = 1'b0;
    push("jal_fetch",  1, 0, mk(1,0,0,1,1,0, 0,2,2,3,0,0));
    push("jal_decode", 1, 0, mk(0,0,0,0,0,0, 1,1,0,3,0,0));
    push("jal_pc",     1, 0, mk(0,0,0,0,1,0, 1,2,0,3,0,0));
    push("jal_wb",     1, 0, mk(0,0,0,0,0,1, 0,0,0,3,0,0));
    n_ret++;
    while (exp_q.size() != 0) begin
      exp_t e; string l;
      apply_next(); e = exp_q.pop_front(); l = lbl_q.pop_front();
      checks++;
      if (got !== e.o) begin failures++; $display("FAIL jal %s outs got=%h exp=%h", l, got, e.o); end
      checks++;
      if (instret !== e.ir) begin failures++; $display("FAIL jal %s instret got=%0d exp=%0d", l, instret, e.ir); end
    end
  endtask

  task automatic test_beq();
    cur_op = 7'b1100011; cur_f3 = 3'b000; cur_f7 = 1'b0;
    for (int z = 1; z >= 0; z--) begin
      cur_z = 1'(z);
      push("beq_fetch",  1, 0, mk(1,0,0,1,1,0, 0,2,2,2,0,0));
      push("beq_decode", 1, 0, mk(0,0,0,0,0,0, 1,1,0,2,0,0));
      push("beq_exec",   1, 0, mk(0,0,0,0,z,0, 2,0,0,2,1,0));
      n_ret++;
    end
    while (exp_q.size() != 0) begin
      exp_t e; string l;
      apply_next(); e = exp_q.pop_front(); l = lbl_q.pop_front();
      checks++;
      if (got !== e.o) begin failures++; $display("FAIL beq %s outs got=%h exp=%h", l, got, e.o); end
      checks++;
      if (instret !== e.ir) begin failures++; $display("FAIL beq %s instret got=%0d exp=%0d", l, instret, e.ir); end
    end
    cur_z = 1'b0;
  endtask

  task automatic test_illegal();
    cur_op = 7'b0000000; cur_f3 = 3'b000; cur_f7 = 1'b0;
    push("ill_fetch",  1, 0, mk(1,0,0,1,1,0, 0,2,2,0,0,0));
    push("ill_decode", 1, 0, mk(0,0,0,0,0,0, 1,1,0,0,0,1));
    push("ill_after",  0, 0, mk(1,0,0,0,0,0, 0,2,2,0,0,0));
    while (exp_q.size() != 0) begin
      exp_t e; string l;
      apply_next(); e = exp_q.pop_front(); l = lbl_q.pop_front();
      checks++;
      if (got !== e.o) begin failures++; $display("FAIL illegal %s outs got=%h exp=%h", l, got, e.o); end
      checks++;
      if (instret !== e.ir) begin failures++; $display("FAIL illegal %s instret got=%0d exp=%0d", l, instret, e.ir); end
    end
  endtask

  // addi with funct7b5 set must still add; eight retirements carry instret past its wrap.
  task automatic test_back_to_back();
    cur_op = 7'b0010011; cur_f3 = 3'b000; cur_f7 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push("i_fetch",  1, 0, mk(1,0,0,1,1,0, 0,2,2,0,0,0));
      push("i_decode", 1, 0, mk(0,0,0,0,0,0, 1,1,0,0,0,0));
      push("i_exec",   1, 0, mk(0,0,0,0,0,0, 2,1,0,0,0,0));
      push("i_wb",     1, 0, mk(0,0,0,0,0,1, 0,0,0,0,0,0));
      n_ret++;
    end
    push("i_wrapped", 0, 0, mk(1,0,0,0,0,0, 0,2,2,0,0,0));
    while (exp_q.size() != 0) begin
      exp_t e; string l;
      apply_next(); e = exp_q.pop_front(); l = lbl_q.pop_front();
      checks++;
      if (got !== e.o) begin failures++; $display("FAIL b2b %s outs got=%h exp=%h", l, got, e.o); end
      checks++;
      if (instret !== e.ir) begin failures++; $display("FAIL b2b %s instret got=%0d exp=%0d", l, instret, e.ir); end
    end
  endtask

  task automatic test_reset_in_wait();
    cur_op = 7'b0000011; cur_f3 = 3'b010; cur_f7 = 1'b0;
    push("rw_fetch",   1, 0, mk(1,0,0,1,1,0, 0,2,2,0,0,0));
    push("rw_decode",  1, 0, mk(0,0,0,0,0,0, 1,1,0,0,0,0));
    push("rw_memadr",  1, 0, mk(0,0,0,0,0,0, 2,1,0,0,0,0));
    push("rw_wait",    0, 0, mk(1,1,0,0,0,0, 0,0,0,0,0,0));
    push("rw_rst",     0, 1, mk(1,1,0,0,0,0, 0,0,0,0,0,0));
    n_ret = 0;
    push("rw_after",   0, 0, mk(1,0,0,0,0,0, 0,2,2,0,0,0));
    while (exp_q.size() != 0) begin
      exp_t e; string l;
      apply_next(); e = exp_q.pop_front(); l = lbl_q.pop_front();
      checks++;
      if (got !== e.o) begin failures++; $display("FAIL rst_wait %s outs got=%h exp=%h", l, got, e.o); end
      checks++;
      if (instret !== e.ir) begin failures++; $display("FAIL rst_wait %s instret got=%0d exp=%0d", l, instret, e.ir); end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_jal();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control unit for the multicycle RV32I core: a Moore FSM that steps the shared datapath (one ALU, one unified instruction/data memory, IR/OldPC/ALUOut/Data registers) through fetch, decode, execute, memory and writeback of each instruction. It drives every datapath select and write-enable, and handshakes with a variable-latency unified memory through `mem_req`/`mem_ready`. It also counts retired instructions.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; forces FETCH and clears the counter.
- `op` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7b5` in 1: IR[30].
- `zero` in 1: ALU zero flag, same cycle.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access requested.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = Result.
- `MemWrite` out 1: write strobe to memory.
- `IRWrite` out 1: load IR and OldPC.
- `PCWrite` out 1: load PC.
- `RegWrite` out 1: register file write.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB` out 2: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ImmSrc` out 2: immediate type; I = 00, S = 01, B = 10, J = 11.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `instret` out INSTRET_W: retired-instruction count.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- **Outputs:** all outputs are decoded from state, `op`/`funct3`/`funct7b5`, and `mem_ready`/`zero` where stated. Any signal not listed for a state is 0.
- **Internal signals:**
  - `ALUOp` (00 add, 01 sub, 10 funct-decoded) feeds the ALU decoder.
  - `PCUpdate` and `Branch` combine as PCWrite = PCUpdate | (Branch & zero).

Per-state outputs and next state:
- **FETCH:**
  - Outputs: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite = PCUpdate = mem_ready.
  - Next: DECODE when mem_ready = 1, else stay in FETCH.
- **DECODE:**
  - Outputs: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00.
  - Next by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other → FETCH, with `illegal_op` = 1 this cycle.
- **MEMADR:**
  - Outputs: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00.
  - Next: MEMREAD if op = 0000011, else MEMWRITE.
- **MEMREAD:**
  - Outputs: mem_req = 1, AdrSrc = 1, ResultSrc = 00.
  - Next: MEMWB on mem_ready, else stay.
- **MEMWB:** ResultSrc = 01, RegWrite = 1. Next: FETCH.
- **MEMWRITE:**
  - Outputs: mem_req = 1, AdrSrc = 1, ResultSrc = 00, MemWrite = 1; held every cycle until mem_ready.
  - Next: FETCH on mem_ready, else stay.
- **EXECUTER:** ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Next: ALUWB.
- **EXECUTEI:** ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Next: ALUWB.
- **ALUWB:** ResultSrc = 00, RegWrite = 1. Next: FETCH.
- **BEQ:**
  - Outputs: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1.
  - Next: FETCH.
- **JAL:**
  - Outputs: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1.
  - Next: ALUWB.

Immediate select (ImmSrc), decoded from `op` in every state:
- 0100011 → 01
- 1100011 → 10
- 1101111 → 11
- all other opcodes → 00

ALU decoder:
- ALUOp 00 → 000 (add); ALUOp 01 → 001 (sub).
- ALUOp 10, by funct3:
  - 000 → 001 if {op[5], funct7b5} = 11, else 000
  - 010 → 101
  - 110 → 011
  - 111 → 010
  - any other → 000

Retired-instruction counter:
- `instret` increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (with mem_ready), ALUWB or BEQ.
- An illegal opcode does not increment it.
- The counter wraps modulo 2^INSTRET_W.

## Timing
- Reset:
  - Next edge: state = FETCH, instret = 0.
  - Outputs in the first post-reset cycle: mem_req = 1, AdrSrc = 0, IRWrite = PCWrite = mem_ready; all other enables 0.
  - Reset overrides any in-progress memory wait; MemWrite drops the cycle after reset is sampled.
- Latency with mem_ready held at 1:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
- Each cycle of mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable throughout a wait.
- Enable pulse widths:
  - IRWrite and PCWrite are each high for exactly one cycle per fetch.
  - RegWrite is high for exactly one cycle per writeback.
- `zero` is sampled combinationally only in BEQ.
- `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.

## Structure
- Package `riscv_mc_pkg` holds:
  - the `statetype_t` enum
  - `ALUOp` codes
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings
  - ALUControl codes
- One sub-module, `aludec` (inputs op[5], funct3, funct7b5, ALUOp; output ALUControl), purely combinational.
- The FSM state register, next-state logic, output decode, immediate-select decode and instret counter live in `multicycle_ctrl`.

## Test plan
- **lw:** reset, op = 0000011, mem_ready = 1.
  - States: FETCH → DECODE → MEMADR → MEMREAD → MEMWB → FETCH.
  - RegWrite = 1 only in cycle 5, with ResultSrc = 01.
  - instret: 0 → 1.
- **sw with memory stall:** op = 0100011, mem_ready = 0 for 2 cycles in MEMWRITE.
  - MemWrite = 1 for 3 consecutive cycles with AdrSrc = 1.
  - PCWrite = 0 throughout.
  - Then FETCH.
- **R-type decode:** op = 0110011.
  - funct3 = 000, funct7b5 = 1 → ALUControl = 001 in EXECUTER.
  - funct3 = 111 → 010; funct3 = 010 → 101.
- **beq:** op = 1100011.
  - zero = 1 → PCWrite = 1 in BEQ.
  - zero = 0 → PCWrite = 0.
  - Back to FETCH after 3 cycles either way.
- **Illegal opcode:** op = 0000000.
  - DECODE → FETCH, with `illegal_op` high for exactly 1 cycle.
  - instret unchanged.
- **Reset during a wait:** reset asserted during a MEMREAD wait with mem_ready = 0.
  - Next cycle: state = FETCH, instret = 0, RegWrite = 0, mem_req = 1 with AdrSrc = 0.
